// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter sharing the single-port SPI RAM command port between two requesters.
// Address/data command pairs are kept atomic and read data is steered back to the issuer.
module spi_ram_arbiter #(
  parameter int unsigned CMD_W        = 10,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned LOCK_TIMEOUT = 255,
  parameter int unsigned RD_TIMEOUT   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid_i,
  input  logic              req1_valid_i,
  input  logic [CMD_W-1:0]  req0_cmd_i,
  input  logic [CMD_W-1:0]  req1_cmd_i,
  output logic              req0_ready_o,
  output logic              req1_ready_o,
  output logic [DATA_W-1:0] req0_rdata_o,
  output logic [DATA_W-1:0] req1_rdata_o,
  output logic              req0_rvalid_o,
  output logic              req1_rvalid_o,
  output logic [CMD_W-1:0]  ram_din_o,
  output logic              ram_rx_valid_o,
  input  logic [DATA_W-1:0] ram_dout_i,
  input  logic              ram_tx_valid_i,
  output logic [1:0]        owner_o,
  output logic              lock_drop_o,
  output logic              rd_timeout_o
);

  localparam int unsigned LCW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam int unsigned RCW = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;
  localparam logic [LCW-1:0] LOCK_LIM = LCW'(LOCK_TIMEOUT);
  localparam logic [RCW-1:0] RD_LIM   = RCW'(RD_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LOCKED, S_WAIT_RD} state_e;

  state_e            state_q;
  logic              last_grant_q;
  logic              owner_id_q;
  logic [LCW-1:0]    lock_cnt_q;
  logic [RCW-1:0]    rd_cnt_q;
  logic [CMD_W-1:0]  ram_din_q;
  logic              ram_rx_valid_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              rvalid0_q, rvalid1_q;
  logic              lock_drop_q, rd_timeout_q;

  logic              grant_vld;
  logic              grant_id;
  logic [CMD_W-1:0]  grant_cmd;
  logic [1:0]        grant_op;
  logic [1:0]        valid;
  logic [LCW-1:0]    lock_inc;
  logic [RCW-1:0]    rd_inc;

  assign valid = {req1_valid_i, req0_valid_i};

  // Ready is gated by valid so only an actual transfer ever sees it; held low in reset.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          if (valid[0] && valid[1]) begin
            grant_vld = 1'b1;
            grant_id  = ~last_grant_q;
          end else if (valid[0]) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
          end else if (valid[1]) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
          end
        end
        S_LOCKED: begin
          if (valid[owner_id_q]) begin
            grant_vld = 1'b1;
            grant_id  = owner_id_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant_cmd    = grant_id ? req1_cmd_i : req0_cmd_i;
  assign grant_op     = grant_cmd[CMD_W-1 -: 2];
  assign req0_ready_o = grant_vld & ~grant_id;
  assign req1_ready_o = grant_vld & grant_id;

  assign lock_inc = (lock_cnt_q == LOCK_LIM) ? lock_cnt_q : lock_cnt_q + LCW'(1);
  assign rd_inc   = (rd_cnt_q == RD_LIM) ? rd_cnt_q : rd_cnt_q + RCW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      last_grant_q   <= 1'b1;
      owner_id_q     <= 1'b0;
      lock_cnt_q     <= '0;
      rd_cnt_q       <= '0;
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      rdata0_q       <= '0;
      rdata1_q       <= '0;
      rvalid0_q      <= 1'b0;
      rvalid1_q      <= 1'b0;
      lock_drop_q    <= 1'b0;
      rd_timeout_q   <= 1'b0;
    end else begin
      ram_rx_valid_q <= grant_vld;
      rvalid0_q      <= 1'b0;
      rvalid1_q      <= 1'b0;
      lock_drop_q    <= 1'b0;
      rd_timeout_q   <= 1'b0;
      if (grant_vld) begin
        ram_din_q    <= grant_cmd;
        last_grant_q <= grant_id;
        owner_id_q   <= grant_id;
        lock_cnt_q   <= '0;
        rd_cnt_q     <= '0;
        case (grant_op)
          2'b01:   state_q <= S_IDLE;
          2'b11:   state_q <= S_WAIT_RD;
          default: state_q <= S_LOCKED;
        endcase
      end else begin
        case (state_q)
          S_LOCKED: begin
            lock_cnt_q <= lock_inc;
            if (lock_inc == LOCK_LIM) begin
              lock_drop_q <= 1'b1;
              lock_cnt_q  <= '0;
              state_q     <= S_IDLE;
            end
          end
          S_WAIT_RD: begin
            // Returned data wins over a timeout landing on the same edge.
            if (ram_tx_valid_i) begin
              if (owner_id_q) begin
                rdata1_q  <= ram_dout_i;
                rvalid1_q <= 1'b1;
              end else begin
                rdata0_q  <= ram_dout_i;
                rvalid0_q <= 1'b1;
              end
              state_q <= S_IDLE;
            end else begin
              rd_cnt_q <= rd_inc;
              if (rd_inc == RD_LIM) begin
                if (owner_id_q) begin
                  rdata1_q  <= '0;
                  rvalid1_q <= 1'b1;
                end else begin
                  rdata0_q  <= '0;
                  rvalid0_q <= 1'b1;
                end
                rd_timeout_q <= 1'b1;
                rd_cnt_q     <= '0;
                state_q      <= S_IDLE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ram_din_o      = ram_din_q;
  assign ram_rx_valid_o = ram_rx_valid_q;
  assign req0_rdata_o   = rdata0_q;
  assign req1_rdata_o   = rdata1_q;
  assign req0_rvalid_o  = rvalid0_q;
  assign req1_rvalid_o  = rvalid1_q;
  assign lock_drop_o    = lock_drop_q;
  assign rd_timeout_o   = rd_timeout_q;
  assign owner_o        = (state_q == S_IDLE) ? 2'b00 : (owner_id_q ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with LOCK_TIMEOUT=4, RD_TIMEOUT=8.
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v0, v1;
  logic [9:0] c0, c1;
  logic       ready0, ready1;
  logic [7:0] rdata0, rdata1;
  logic       rvalid0, rvalid1;
  logic [9:0] ram_din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       txv;
  logic [1:0] owner;
  logic       lock_drop, rd_to;

  int checks   = 0;
  int failures = 0;

  spi_ram_arbiter #(
    .CMD_W(10), .DATA_W(8), .LOCK_TIMEOUT(4), .RD_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(v0), .req1_valid_i(v1),
    .req0_cmd_i(c0), .req1_cmd_i(c1),
    .req0_ready_o(ready0), .req1_ready_o(ready1),
    .req0_rdata_o(rdata0), .req1_rdata_o(rdata1),
    .req0_rvalid_o(rvalid0), .req1_rvalid_o(rvalid1),
    .ram_din_o(ram_din), .ram_rx_valid_o(rx_valid),
    .ram_dout_i(dout), .ram_tx_valid_i(txv),
    .owner_o(owner), .lock_drop_o(lock_drop), .rd_timeout_o(rd_to)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; c0 = '0; c1 = '0; txv = 1'b0; dout = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; c0 = 10'h3FF; c1 = 10'h3FF; txv = 1'b0; dout = 8'h5A;
    step(); step();
    checks++; if (ready0 !== 1'b0) begin failures++; $display("FAIL rst_ready0 got=%b exp=0", ready0); end
    checks++; if (ready1 !== 1'b0) begin failures++; $display("FAIL rst_ready1 got=%b exp=0", ready1); end
    checks++; if (ram_din !== 10'h000) begin failures++; $display("FAIL rst_din got=%h exp=000", ram_din); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
    checks++; if ({rdata1, rdata0} !== 16'h0000) begin failures++; $display("FAIL rst_rdata got=%h exp=0000", {rdata1, rdata0}); end
    checks++; if ({rvalid1, rvalid0} !== 2'b00) begin failures++; $display("FAIL rst_rvalid got=%b exp=00", {rvalid1, rvalid0}); end
    checks++; if (owner !== 2'b00) begin failures++; $display("FAIL rst_owner got=%b exp=00", owner); end
    checks++; if ({lock_drop, rd_to} !== 2'b00) begin failures++; $display("FAIL rst_pulses got=%b exp=00", {lock_drop, rd_to}); end
    rst_n = 1'b1;
    #1;
    checks++; if ({ready1, ready0} !== 2'b01) begin failures++; $display("FAIL rel_ready got=%b exp=01", {ready1, ready0}); end
    step();
    v0 = 1'b0; v1 = 1'b0;
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL rel_rx_valid got=%b exp=1", rx_valid); end
    checks++; if (ram_din !== 10'h3FF) begin failures++; $display("FAIL rel_din got=%h exp=3ff", ram_din); end
    checks++; if (owner !== 2'b01) begin failures++; $display("FAIL rel_owner got=%b exp=01", owner); end
    step();
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rel_strobe_width got=%b exp=0", rx_valid); end
  endtask

  task automatic test_lock_atomic();
    do_reset();
    v0 = 1'b1; c0 = 10'h005; v1 = 1'b1; c1 = 10'h010;
    #1;
    checks++; if ({ready1, ready0} !== 2'b01) begin failures++; $display("FAIL lk_ready_a got=%b exp=01", {ready1, ready0}); end
    step();
    checks++; if (ram_din !== 10'h005) begin failures++; $display("FAIL lk_din_a got=%h exp=005", ram_din); end
    checks++; if (owner !== 2'b01) begin failures++; $display("FAIL lk_owner_a got=%b exp=01", owner); end
    c0 = 10'h1AB;
    #1;
    checks++; if ({ready1, ready0} !== 2'b01) begin failures++; $display("FAIL lk_ready_b got=%b exp=01", {ready1, ready0}); end
    step();
    checks++; if (ram_din !== 10'h1AB || rx_valid !== 1'b1) begin failures++; $display("FAIL lk_din_b got=%h/%b exp=1ab/1", ram_din, rx_valid); end
    checks++; if (owner !== 2'b00) begin failures++; $display("FAIL lk_owner_b got=%b exp=00", owner); end
    v0 = 1'b0;
    #1;
    checks++; if ({ready1, ready0} !== 2'b10) begin failures++; $display("FAIL lk_ready_c got=%b exp=10", {ready1, ready0}); end
    step();
    v1 = 1'b0;
    checks++; if (ram_din !== 10'h010 || rx_valid !== 1'b1) begin failures++; $display("FAIL lk_din_c got=%h/%b exp=010/1", ram_din, rx_valid); end
    checks++; if (owner !== 2'b10) begin failures++; $display("FAIL lk_owner_c got=%b exp=10", owner); end
  endtask

  task automatic test_read();
    do_reset();
    v1 = 1'b1; c1 = 10'h205;
    step();
    checks++; if (ram_din !== 10'h205 || owner !== 2'b10) begin failures++; $display("FAIL rd_addr got=%h/%b exp=205/10", ram_din, owner); end
    c1 = 10'h300;
    step();
    v1 = 1'b0;
    checks++; if (ram_din !== 10'h300 || rx_valid !== 1'b1) begin failures++; $display("FAIL rd_cmd got=%h/%b exp=300/1", ram_din, rx_valid); end
    step();
    step();
    txv = 1'b1; dout = 8'hAB;
    step();
    txv = 1'b0; dout = 8'h00;
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== 8'hAB) begin failures++; $display("FAIL rd_ret got=%b/%h exp=1/ab", rvalid1, rdata1); end
    checks++; if (rvalid0 !== 1'b0) begin failures++; $display("FAIL rd_other got=%b exp=0", rvalid0); end
    checks++; if (owner !== 2'b00 || rd_to !== 1'b0) begin failures++; $display("FAIL rd_owner got=%b/%b exp=00/0", owner, rd_to); end
    txv = 1'b1; dout = 8'h77;
    step();
    txv = 1'b0;
    checks++; if (rvalid1 !== 1'b0 || rdata1 !== 8'hAB) begin failures++; $display("FAIL rd_stray got=%b/%h exp=0/ab", rvalid1, rdata1); end
    step();
    checks++; if ({rvalid1, rvalid0} !== 2'b00 || rdata1 !== 8'hAB) begin failures++; $display("FAIL rd_hold got=%b/%h exp=00/ab", {rvalid1, rvalid0}, rdata1); end
  endtask

  task automatic test_read_timeout();
    v1 = 1'b1; c1 = 10'h300;
    #1;
    checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL to_ready got=%b exp=1", ready1); end
    step();
    v1 = 1'b0; v0 = 1'b1; c0 = 10'h100;
    #1;
    checks++; if (ready0 !== 1'b0 || owner !== 2'b10) begin failures++; $display("FAIL to_stall got=%b/%b exp=0/10", ready0, owner); end
    for (int i = 0; i < 7; i++) begin
      step();
      checks++; if (rvalid1 !== 1'b0 || rd_to !== 1'b0 || ready0 !== 1'b0) begin failures++; $display("FAIL to_early cyc=%0d got=%b%b%b exp=000", i, rvalid1, rd_to, ready0); end
    end
    step();
    v0 = 1'b0;
    checks++; if (rvalid1 !== 1'b1 || rd_to !== 1'b1) begin failures++; $display("FAIL to_pulse got=%b/%b exp=1/1", rvalid1, rd_to); end
    checks++; if (rdata1 !== 8'h00 || owner !== 2'b00) begin failures++; $display("FAIL to_data got=%h/%b exp=00/00", rdata1, owner); end
    step();
    checks++; if (rvalid1 !== 1'b0 || rd_to !== 1'b0) begin failures++; $display("FAIL to_width got=%b/%b exp=0/0", rvalid1, rd_to); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_cmd;
    do_reset();
    v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      c0 = 10'h100 | 10'(i);
      c1 = 10'h180 | 10'(i);
      exp_cmd = (i % 2 == 0) ? c0 : c1;
      #1;
      checks++; if ({ready1, ready0} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin failures++; $display("FAIL b2b_ready i=%0d got=%b", i, {ready1, ready0}); end
      step();
      checks++; if (rx_valid !== 1'b1 || ram_din !== exp_cmd) begin failures++; $display("FAIL b2b_din i=%0d got=%h/%b exp=%h/1", i, ram_din, rx_valid, exp_cmd); end
    end
    v0 = 1'b0; v1 = 1'b0;
    step();
  endtask

  task automatic test_lock_timeout();
    do_reset();
    v0 = 1'b1; c0 = 10'h00A;
    step();
    v0 = 1'b0; v1 = 1'b1; c1 = 10'h1CC;
    step(); step();
    checks++; if (lock_drop !== 1'b0 || owner !== 2'b01 || ready1 !== 1'b0) begin failures++; $display("FAIL lt_pre got=%b/%b/%b exp=0/01/0", lock_drop, owner, ready1); end
    v0 = 1'b1; c0 = 10'h00B;
    step();
    v0 = 1'b0;
    checks++; if (ram_din !== 10'h00B || rx_valid !== 1'b1) begin failures++; $display("FAIL lt_readdr got=%h/%b exp=00b/1", ram_din, rx_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (lock_drop !== 1'b0 || owner !== 2'b01 || ready1 !== 1'b0) begin failures++; $display("FAIL lt_hold cyc=%0d got=%b/%b/%b exp=0/01/0", i, lock_drop, owner, ready1); end
    end
    step();
    checks++; if (lock_drop !== 1'b1 || owner !== 2'b00) begin failures++; $display("FAIL lt_drop got=%b/%b exp=1/00", lock_drop, owner); end
    checks++; if (rx_valid !== 1'b0 || ready1 !== 1'b1) begin failures++; $display("FAIL lt_after got=%b/%b exp=0/1", rx_valid, ready1); end
    step();
    v1 = 1'b0;
    checks++; if (ram_din !== 10'h1CC || rx_valid !== 1'b1 || lock_drop !== 1'b0) begin failures++; $display("FAIL lt_grant got=%h/%b/%b exp=1cc/1/0", ram_din, rx_valid, lock_drop); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    v0 = 1'b1; c0 = 10'h300;
    step();
    v0 = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (owner !== 2'b00 || rx_valid !== 1'b0) begin failures++; $display("FAIL mr_reset got=%b/%b exp=00/0", owner, rx_valid); end
    for (int i = 0; i < 12; i++) begin
      txv  = (i == 2) ? 1'b1 : 1'b0;
      dout = 8'h99;
      step();
      checks++; if (rvalid0 !== 1'b0 || rd_to !== 1'b0 || rdata0 !== 8'h00 || lock_drop !== 1'b0) begin failures++; $display("FAIL mr_quiet cyc=%0d got=%b/%b/%h/%b exp=0/0/00/0", i, rvalid0, rd_to, rdata0, lock_drop); end
    end
    txv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_atomic();
    test_read();
    test_read_timeout();
    test_back_to_back();
    test_lock_timeout();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Two-requester arbiter that shares the single-port RAM (10-bit command in, 8-bit data out) between the SPI slave front end (port 0) and a local host/debug requester (port 1). It forwards 10-bit RAM commands from one requester at a time and keeps address/data command pairs atomic, so the RAM's single write-address and read-address registers are never corrupted by interleaving. It routes read data back to the requester that issued the read. It sits between the requesters and the RAM `din/rx_valid/dout/tx_valid` port.

## Interface
- CMD_W, 10, RAM command width; bits [CMD_W-1:CMD_W-2] are the opcode.
- DATA_W, 8, RAM data width.
- LOCK_TIMEOUT, 255, idle cycles allowed for the owner of a lock before the lock is dropped.
- RD_TIMEOUT, 8, cycles allowed between read issue and `ram_tx_valid`.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req0_valid / req1_valid  in  1  requester has a command
- req0_cmd / req1_cmd  in  CMD_W  command word
- req0_ready / req1_ready  out  1  command accepted this cycle (combinational)
- req0_rdata / req1_rdata  out  DATA_W  returned read data
- req0_rvalid / req1_rvalid  out  1  one-cycle pulse, rdata valid
- ram_din  out  CMD_W  command to RAM
- ram_rx_valid  out  1  one-cycle command strobe to RAM
- ram_dout  in  DATA_W  RAM read data
- ram_tx_valid  in  1  RAM read data valid
- owner  out  2  bit i set while requester i holds the lock or has a read outstanding
- lock_drop  out  1  one-cycle pulse: lock released by LOCK_TIMEOUT
- rd_timeout  out  1  one-cycle pulse: read abandoned by RD_TIMEOUT

## Operation
- Opcodes: 00 = write address, 01 = write data, 10 = read address, 11 = read data (RAM responds with `ram_tx_valid`).
- A transfer occurs at a rising edge with `reqi_valid && reqi_ready`. The accepted cmd is registered into `ram_din`, and `ram_rx_valid` is high for exactly the next cycle.
- States: IDLE, LOCKED, WAIT_RD.
- IDLE:
  - Arbitrate among valid requesters, round-robin. The winner is the requester not granted last; `last_grant` resets to 1, so port 0 wins the first tie. Only the winner sees ready.
  - Opcode 00/10 goes to LOCKED with owner = winner. Opcode 01 stays in IDLE. Opcode 11 goes to WAIT_RD.
- LOCKED:
  - Only the owner's ready may assert. The other requester is stalled.
  - Owner 01 goes to IDLE. Owner 11 goes to WAIT_RD. Owner 00/10 re-addresses and stays LOCKED, restarting the lock counter.
  - The lock counter increments on each cycle with no owner transfer. When it reaches LOCK_TIMEOUT: pulse `lock_drop`, go to IDLE, forward nothing.
- WAIT_RD:
  - No ready asserts. The read counter starts at 0 in the cycle after acceptance.
  - On `ram_tx_valid` sampled high: register `ram_dout` to `reqi_rdata` of the issuing requester, pulse `reqi_rvalid` the next cycle, go to IDLE.
  - When the counter reaches RD_TIMEOUT: rdata = 0, pulse `rvalid` and `rd_timeout` together, go to IDLE.
- `ram_tx_valid` outside WAIT_RD is ignored.
- `last_grant` updates on every accepted command.
- Counter widths are $clog2(limit+1). Counters saturate and never wrap.

## Timing
- Reset values:
  - State IDLE; `last_grant` = 1; counters 0.
  - `ram_din` = 0, `ram_rx_valid` = 0.
  - All `rdata` = 0 and all `rvalid` = 0.
  - `owner` = 0, `lock_drop` = 0, `rd_timeout` = 0.
  - Both ready = 0 while rst_n is low.
- Command latency: accept at edge N puts `ram_din`/`ram_rx_valid` valid in cycle N+1.
- Throughput: back-to-back accepts are allowed in IDLE/LOCKED, one per cycle, giving a continuous `ram_rx_valid`.
- Read latency: if `ram_tx_valid` is sampled at edge M, `rvalid` is high in cycle M+1. The next accept can occur at edge M+1.
- `rdata` holds its value until the next read returns to that port.
- Reset mid-operation: the next edge returns to IDLE. No `rvalid` or timeout pulse is produced for the aborted transaction, and an outstanding read is discarded.
- Requester dropping valid without a transfer: no effect on state except the lock counter advancing.

## Test plan
- Reset with both valid high and cmd = 0x3FF: all outputs 0, no ready. Release reset: port 0 wins, `ram_din` = 0x3FF with `ram_rx_valid` one cycle later.
- Port 0 sends 0x005 (write addr 5) then 0x1AB while port 1 holds 0x010 valid: sequence on `ram_din` is 0x005, 0x1AB, 0x010. Port 1 ready stays low until port 0's 0x1AB is accepted.
- Port 1 sends 0x205 then 0x300, and the RAM model returns 0xAB two cycles after the strobe: `req1_rdata` = 0xAB with `req1_rvalid` one cycle after `tx_valid`. `req0_rvalid` stays 0.
- Both ports continuously send 0x1xx: grants alternate 0,1,0,1 and `ram_rx_valid` stays high every cycle.
- Owner sends 0x00A then idles with LOCK_TIMEOUT = 4: `lock_drop` pulses after 4 idle cycles, then the other port is granted.
- Read with RAM silent and RD_TIMEOUT = 8: `rvalid` and `rd_timeout` pulse together with rdata 0x00. Assert rst_n low in WAIT_RD on a separate run: no pulses follow.
